// File: rtl/dvp_tx_pkg.sv
// rtl/dvp_tx_pkg.sv - shared types and constants for the DVP pattern transmitter
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VS,
        VBP,
        ACTIVE,
        VFP
    } state_e;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_SOLID = 2'd2;
    localparam logic [1:0] PAT_PRBS  = 2'd3;

    localparam logic [9:0] BAR_STEP  = 10'h080;
    localparam logic [9:0] BAR_TOP   = 10'h3FF;
    localparam logic [9:0] PRBS_SEED = 10'h3FF;

    // x^10 + x^7 + 1, shifting towards the MSB
    function automatic logic [9:0] prbs10_next(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

endpackage

// File: rtl/dvp_tx_pattern.sv
// rtl/dvp_tx_pattern.sv - pixel value generator (bars/ramp/solid, PRBS10 when DVP_TX_PRBS_EN)
module dvp_tx_pattern
    import dvp_tx_pkg::*;
#(
    parameter int H_RES = 640
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] x,
    input  logic        active,
    input  logic [1:0]  mode,
    input  logic [9:0]  solid,
    input  logic        frame_start,
    output logic [9:0]  pixel
);

    localparam logic [11:0] BAR_W = 12'(H_RES / 8);

    logic [11:0] bar_k;
    logic [9:0]  bar_val;

`ifdef DVP_TX_PRBS_EN
    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    // lfsr_q always holds the value for the next HREF-high pixel
    always_comb begin
        lfsr_d = lfsr_q;
        if (frame_start) begin
            lfsr_d = PRBS_SEED;
        end else if (active) begin
            lfsr_d = prbs10_next(lfsr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= PRBS_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic unused_prbs;
    assign unused_prbs = ^{clk, rst_n, frame_start};
`endif

    always_comb begin
        bar_k   = x / BAR_W;
        bar_val = BAR_TOP - 10'(10'(bar_k) * BAR_STEP);
        pixel   = '0;
        if (active) begin
            case (mode)
                PAT_RAMP:  pixel = x[9:0];
                PAT_SOLID: pixel = solid;
`ifdef DVP_TX_PRBS_EN
                PAT_PRBS:  pixel = lfsr_q;
`endif
                default:   pixel = bar_val;
            endcase
        end
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// rtl/dvp_pattern_tx.sv - DVP frame timing and registered outputs; DVP_TX_PRBS_EN enables pattern 3 PRBS10
module dvp_pattern_tx
    import dvp_tx_pkg::*;
#(
    parameter int   H_RES     = 640,
    parameter int   H_BLANK   = 144,
    parameter int   V_RES     = 480,
    parameter int   VS_LINES  = 3,
    parameter int   VBP_LINES = 17,
    parameter int   VFP_LINES = 10,
    parameter logic VS_POL    = 1'b0
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_en,
    input  logic [1:0] I_pattern,
    input  logic [9:0] I_solid,
    output logic       O_vsync,
    output logic       O_href,
    output logic [9:0] O_pixdata,
    output logic       O_frame_done,
    output logic       O_busy
);

    localparam logic [11:0] LP_LAST   = 12'(H_RES + H_BLANK - 1);
    localparam logic [11:0] H_ACT     = 12'(H_RES);
    localparam logic [11:0] VS_LAST   = 12'(VS_LINES - 1);
    localparam logic [11:0] VBP_LAST  = 12'(VBP_LINES - 1);
    localparam logic [11:0] ACT_LAST  = 12'(V_RES - 1);
    localparam logic [11:0] VFP_LAST  = 12'(VFP_LINES - 1);

    state_e      state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] lcnt_q, lcnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [9:0]  solid_q, solid_d;
    logic        vsync_q, vsync_d;
    logic        href_q, href_d;
    logic [9:0]  pix_q, pix_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        last_line;
    logic        frame_start;
    logic [9:0]  pixel;

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        case (state_q)
            VS:      last_line = (lcnt_q == VS_LAST);
            VBP:     last_line = (lcnt_q == VBP_LAST);
            ACTIVE:  last_line = (lcnt_q == ACT_LAST);
            VFP:     last_line = (lcnt_q == VFP_LAST);
            default: last_line = 1'b0;
        endcase

        if (state_q == IDLE) begin
            hcnt_d = '0;
            lcnt_d = '0;
            if (I_en) begin
                state_d = VS;
            end
        end else if (hcnt_q == LP_LAST) begin
            hcnt_d = '0;
            if (last_line) begin
                lcnt_d = '0;
                case (state_q)
                    VS:      state_d = VBP;
                    VBP:     state_d = ACTIVE;
                    ACTIVE:  state_d = VFP;
                    VFP:     state_d = I_en ? VS : IDLE;
                    default: state_d = IDLE;
                endcase
            end else begin
                lcnt_d = lcnt_q + 12'd1;
            end
        end else begin
            hcnt_d = hcnt_q + 12'd1;
        end
    end

    // Outputs are decoded from the next state so they register on the same edge as the state change
    always_comb begin
        frame_start = (state_d == VS) && (state_q != VS);
        mode_d      = frame_start ? I_pattern : mode_q;
        solid_d     = frame_start ? I_solid : solid_q;
        vsync_d     = (state_d == VS) ? VS_POL : ~VS_POL;
        href_d      = (state_d == ACTIVE) && (hcnt_d < H_ACT);
        pix_d       = pixel;
        done_d      = (state_d == VFP) && (hcnt_d == LP_LAST) && (lcnt_d == VFP_LAST);
        busy_d      = (state_d != IDLE);
    end

    dvp_tx_pattern #(
        .H_RES(H_RES)
    ) u_pattern (
        .clk        (I_clk),
        .rst_n      (I_rst_n),
        .x          (hcnt_d),
        .active     (href_d),
        .mode       (mode_q),
        .solid      (solid_q),
        .frame_start(frame_start),
        .pixel      (pixel)
    );

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
            mode_q  <= PAT_BARS;
            solid_q <= '0;
            vsync_q <= ~VS_POL;
            href_q  <= 1'b0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            mode_q  <= mode_d;
            solid_q <= solid_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign O_vsync      = vsync_q;
    assign O_href       = href_q;
    assign O_pixdata    = pix_q;
    assign O_frame_done = done_q;
    assign O_busy       = busy_q;

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb/tb_dvp_pattern_tx.sv - scoreboard bench for dvp_pattern_tx on a reduced frame geometry
module tb_dvp_pattern_tx;

    localparam int H_RES     = 16;
    localparam int H_BLANK   = 4;
    localparam int V_RES     = 3;
    localparam int VS_LINES  = 2;
    localparam int VBP_LINES = 1;
    localparam int VFP_LINES = 1;
    localparam int LP        = H_RES + H_BLANK;
    localparam int FRAME     = LP * (VS_LINES + VBP_LINES + V_RES + VFP_LINES);

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic [9:0] solid = 10'd0;
    logic       vsync, href, frame_done, busy;
    logic [9:0] pix;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];
    int vs_low, href_cnt, pulses, busy_cnt, fd_cnt, fd_at, cyc;
    logic href_prev;

    dvp_pattern_tx #(
        .H_RES(H_RES), .H_BLANK(H_BLANK), .V_RES(V_RES),
        .VS_LINES(VS_LINES), .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES), .VS_POL(1'b0)
    ) dut (
        .I_clk(clk), .I_rst_n(rst_n), .I_en(en), .I_pattern(pattern), .I_solid(solid),
        .O_vsync(vsync), .O_href(href), .O_pixdata(pix), .O_frame_done(frame_done), .O_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [1:0] mode, input logic [9:0] sv);
        logic [9:0] v;
        v = 10'h3FF;
        for (int l = 0; l < V_RES; l++) begin
            for (int x = 0; x < H_RES; x++) begin
                logic [9:0] bar;
                bar = 10'('h3FF - (x / (H_RES / 8)) * 'h80);
                case (mode)
                    2'd1: exp_q.push_back(10'(x));
                    2'd2: exp_q.push_back(sv);
`ifdef DVP_TX_PRBS_EN
                    2'd3: begin
                        exp_q.push_back(v);
                        v = {v[8:0], v[9] ^ v[6]};
                    end
`endif
                    default: exp_q.push_back(bar);
                endcase
            end
        end
    endtask

    task automatic clr();
        vs_low = 0; href_cnt = 0; pulses = 0; busy_cnt = 0;
        fd_cnt = 0; fd_at = -1; cyc = 0; href_prev = 1'b0;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (vsync == 1'b0) vs_low++;
            if (busy) busy_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = cyc;
            end
            if (href && !href_prev) pulses++;
            href_prev = href;
            if (href) begin
                href_cnt++;
                if (exp_q.size() == 0) check("pix_underflow", 1, 0);
                else check("pixdata", 32'(pix), 32'(exp_q.pop_front()));
            end else begin
                check("pix_blank", 32'(pix), 0);
            end
            cyc++;
        end
    endtask

    task automatic tally(input string tag, input int nf);
        check({tag, "_vs_low"}, vs_low, nf * VS_LINES * LP);
        check({tag, "_href_clks"}, href_cnt, nf * V_RES * H_RES);
        check({tag, "_href_pulses"}, pulses, nf * V_RES);
        check({tag, "_busy"}, busy_cnt, nf * FRAME);
        check({tag, "_frame_done"}, fd_cnt, nf);
        check({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic idle_check(input string tag);
        clr();
        watch(5);
        check({tag, "_busy"}, busy_cnt, 0);
        check({tag, "_vs_low"}, vs_low, 0);
        check({tag, "_href"}, href_cnt, 0);
        check({tag, "_vsync"}, vsync, 1);
    endtask

    initial begin
        int  t;
        logic found;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_vsync", vsync, 1);
        check("rst_href", href, 0);
        check("rst_pix", pix, 0);
        check("rst_done", frame_done, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        idle_check("idle_no_en");

        // Frame 1: bars, check timing of the first VSYNC and of frame_done
        en = 1'b1;
        pattern = 2'd0;
        push_frame(2'd0, 10'd0);
        clr();
        watch(1);
        check("vs_first", vsync, 0);
        check("busy_first", busy, 1);
        watch(FRAME - 1);
        check("fd_last_clk", fd_at, FRAME - 1);
        tally("f1", 1);

        // Frames 2-3: pattern switched mid-frame only applies to the next frame
        push_frame(2'd0, 10'd0);
        clr();
        watch(FRAME / 2);
        pattern = 2'd2;
        solid = 10'h155;
        push_frame(2'd2, 10'h155);
        watch(FRAME - FRAME / 2);
        watch(FRAME);
        tally("f23", 2);

        // Frame 4: drop enable mid-frame, frame still completes
        push_frame(2'd2, 10'h155);
        clr();
        watch(FRAME / 2);
        en = 1'b0;
        watch(FRAME - FRAME / 2);
        check("f4_fd_last_clk", fd_at, FRAME - 1);
        tally("f4", 1);
        idle_check("idle_after_f4");

        // Async reset during ACTIVE, then restart from VS with the ramp pattern
        pattern = 2'd1;
        en = 1'b1;
        found = 1'b0;
        t = 0;
        while (t < 4 * FRAME && !found) begin
            @(negedge clk);
            if (href) found = 1'b1;
            t++;
        end
        check("reach_active", found, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_href", href, 0);
        check("arst_pix", pix, 0);
        check("arst_vsync", vsync, 1);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(2'd1, 10'd0);
        clr();
        watch(1);
        check("vs_restart", vsync, 0);
        en = 1'b0;
        watch(FRAME - 1);
        check("f5_fd_last_clk", fd_at, FRAME - 1);
        tally("f5", 1);
        idle_check("idle_after_f5");

        // Pattern 3, two back-to-back frames to show per-frame reseeding
        pattern = 2'd3;
        en = 1'b1;
        push_frame(2'd3, 10'd0);
        clr();
        watch(FRAME);
        push_frame(2'd3, 10'd0);
        watch(1);
        en = 1'b0;
        watch(FRAME - 1);
        tally("f67", 2);
        idle_check("idle_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
